// File: rtl/l2_cache_assoc.sv
// l2_cache_assoc
// Set-associative, write-back, write-allocate L2 cache sitting between the L1
// miss path and main memory. Both sides move whole lines.
//
// Victim choice is deterministic: the lowest-numbered invalid way in the set,
// otherwise the set's round-robin pointer. Write misses install the incoming
// line directly (ALLOC) because a write always covers the full line.
//
// Parameters:
//   ADDR_W   line address width
//   LINE_W   line data width
//   SET_BITS log2(sets); index = cache_addr[SET_BITS-1:0]
//   WAY_BITS log2(ways)
//
// Ports:
//   clk, cache_reset         clock and synchronous active-high reset
//   cache_read/cache_write   request strobes, held until cache_ready
//   cache_addr, cache_wdata  request line address and write data
//   cache_ready, cache_rdata one-cycle completion pulse and read data
//   mem_read/mem_write       memory request strobes (decoded from state)
//   mem_addr, mem_wdata      memory line address and write-back data
//   mem_rdata, mem_ready     fill data and one-cycle memory completion
//
// Optional build macro L2_CACHE_STATS_EN adds saturating 32-bit counters
// stat_hit, stat_miss and stat_wb.

module l2_cache_assoc #(
  parameter int ADDR_W   = 28,
  parameter int LINE_W   = 128,
  parameter int SET_BITS = 3,
  parameter int WAY_BITS = 2
) (
  input  logic              clk,
  input  logic              cache_reset,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [LINE_W-1:0] cache_wdata,
  output logic              cache_ready,
  output logic [LINE_W-1:0] cache_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef L2_CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hit,
  output logic [31:0]       stat_miss,
  output logic [31:0]       stat_wb
`endif
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WAYS  = 1 << WAY_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FILL,
    S_ALLOC,
    S_RESPOND
  } state_t;

  state_t r_state, w_nextState;

  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAYS-1:0]     r_dirty [SETS];
  logic [WAY_BITS-1:0] r_rr    [SETS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [LINE_W-1:0]   r_data  [SETS][WAYS];
  logic [WAY_BITS-1:0] r_victim;
  logic                r_isWrite;
  logic [LINE_W-1:0]   r_rdata;

  logic [SET_BITS-1:0] w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_req;
  logic                w_hit;
  logic [WAY_BITS-1:0] w_hitWay;
  logic                w_hasInv;
  logic [WAY_BITS-1:0] w_invWay;
  logic [WAY_BITS-1:0] w_victim;
  logic                w_victimDirty;

  assign w_index = cache_addr[SET_BITS-1:0];
  assign w_tag   = cache_addr[ADDR_W-1:SET_BITS];
  // Both strobes high is an illegal request and is simply not accepted.
  assign w_req   = cache_read ^ cache_write;

  // Scan from the top way down so the lowest matching/invalid way wins.
  always_comb begin
    w_hit    = 1'b0;
    w_hitWay = '0;
    w_hasInv = 1'b0;
    w_invWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
        w_hit    = 1'b1;
        w_hitWay = WAY_BITS'(w);
      end
      if (!r_valid[w_index][w]) begin
        w_hasInv = 1'b1;
        w_invWay = WAY_BITS'(w);
      end
    end
  end

  assign w_victim      = w_hasInv ? w_invWay : r_rr[w_index];
  assign w_victimDirty = r_valid[w_index][w_victim] & r_dirty[w_index][w_victim];

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit)              w_nextState = S_RESPOND;
          else if (w_victimDirty) w_nextState = S_WRITEBACK;
          else if (cache_write)   w_nextState = S_ALLOC;
          else                    w_nextState = S_FILL;
        end
      end
      S_WRITEBACK: if (mem_ready) w_nextState = r_isWrite ? S_ALLOC : S_FILL;
      S_FILL:      if (mem_ready) w_nextState = S_RESPOND;
      S_ALLOC:     w_nextState = S_RESPOND;
      S_RESPOND:   w_nextState = S_IDLE;
      default:     w_nextState = S_IDLE;
    endcase
  end

  // Control state: FSM register, valid/dirty bits, round-robin pointers, and
  // the read-data latch. Everything here is cleared by reset.
  always_ff @(posedge clk) begin
    if (cache_reset) begin
      r_state   <= S_IDLE;
      r_victim  <= '0;
      r_isWrite <= 1'b0;
      r_rdata   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (cache_read) r_rdata <= r_data[w_index][w_hitWay];
              else            r_dirty[w_index][w_hitWay] <= 1'b1;
            end else begin
              r_victim  <= w_victim;
              r_isWrite <= cache_write;
              // Filling an invalid way does not consume the pointer.
              if (!w_hasInv) r_rr[w_index] <= r_rr[w_index] + 1'b1;
            end
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            r_valid[w_index][r_victim] <= 1'b1;
            r_dirty[w_index][r_victim] <= 1'b0;
            r_rdata                    <= mem_rdata;
          end
        end
        S_ALLOC: begin
          r_valid[w_index][r_victim] <= 1'b1;
          r_dirty[w_index][r_victim] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity lives in r_valid.
  always_ff @(posedge clk) begin
    if (!cache_reset) begin
      if (r_state == S_IDLE && w_req && w_hit && cache_write) begin
        r_data[w_index][w_hitWay] <= cache_wdata;
      end else if (r_state == S_FILL && mem_ready) begin
        r_data[w_index][r_victim] <= mem_rdata;
        r_tag[w_index][r_victim]  <= w_tag;
      end else if (r_state == S_ALLOC) begin
        r_data[w_index][r_victim] <= cache_wdata;
        r_tag[w_index][r_victim]  <= w_tag;
      end
    end
  end

  assign cache_ready = (r_state == S_RESPOND);
  assign cache_rdata = r_rdata;
  assign mem_write   = (r_state == S_WRITEBACK);
  assign mem_read    = (r_state == S_FILL);
  assign mem_wdata   = r_data[w_index][r_victim];

  always_comb begin
    mem_addr = '0;
    if (r_state == S_WRITEBACK) mem_addr = {r_tag[w_index][r_victim], w_index};
    else if (r_state == S_FILL) mem_addr = cache_addr;
  end

`ifdef L2_CACHE_STATS_EN
  logic [31:0] r_statHit, r_statMiss, r_statWb;

  // Hits and misses count at acceptance in IDLE; write-backs at completion.
  always_ff @(posedge clk) begin
    if (cache_reset) begin
      r_statHit  <= '0;
      r_statMiss <= '0;
      r_statWb   <= '0;
    end else begin
      if (r_state == S_IDLE && w_req && w_hit && r_statHit != 32'hFFFF_FFFF)
        r_statHit <= r_statHit + 32'd1;
      if (r_state == S_IDLE && w_req && !w_hit && r_statMiss != 32'hFFFF_FFFF)
        r_statMiss <= r_statMiss + 32'd1;
      if (r_state == S_WRITEBACK && mem_ready && r_statWb != 32'hFFFF_FFFF)
        r_statWb <= r_statWb + 32'd1;
    end
  end

  assign stat_hit  = r_statHit;
  assign stat_miss = r_statMiss;
  assign stat_wb   = r_statWb;
`endif

endmodule

// File: tb/tb_l2_cache_assoc.sv
// tb_l2_cache_assoc
// Directed self-checking bench for l2_cache_assoc (default parameters).
// A request driver plays both the L1 requester and a one-wait-cycle memory,
// recording what the cache did; each test task compares inline against
// hand-computed values. Define L2_CACHE_STATS_EN to also check the counters.

module tb_l2_cache_assoc;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              cache_reset = 1'b0;
  logic              cache_read = 1'b0;
  logic              cache_write = 1'b0;
  logic [ADDR_W-1:0] cache_addr = '0;
  logic [LINE_W-1:0] cache_wdata = '0;
  logic              cache_ready;
  logic [LINE_W-1:0] cache_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
`ifdef L2_CACHE_STATS_EN
  logic [31:0]       stat_hit, stat_miss, stat_wb;
`endif

  int total = 0;
  int bad = 0;

  int                resLat;
  bit                resRd, resWr;
  logic [ADDR_W-1:0] resWbAddr, resRdAddr;
  logic [LINE_W-1:0] resWbData, resData;

  l2_cache_assoc dut (
    .clk(clk), .cache_reset(cache_reset),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_ready(cache_ready), .cache_rdata(cache_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef L2_CACHE_STATS_EN
    , .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_wb(stat_wb)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic doReset();
    cache_reset = 1'b1;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    mem_ready   = 1'b0;
    @(posedge clk); #1;
    cache_reset = 1'b0;
  endtask

  // Runs one request to completion (bounded), answering each memory request
  // after one wait cycle. Latency is edges from request to cache_ready, or -1.
  task automatic doRequest(input bit isWrite, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wdata,
                           input logic [LINE_W-1:0] memData);
    int cyc;
    bit done;
    cyc = 0; done = 1'b0;
    resRd = 1'b0; resWr = 1'b0;
    resWbAddr = '0; resRdAddr = '0; resWbData = '0; resData = '0;
    cache_addr  = addr;
    cache_wdata = wdata;
    cache_read  = !isWrite;
    cache_write = isWrite;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      mem_ready = 1'b0;
      if (mem_write && !resWr) begin
        resWr = 1'b1; resWbAddr = mem_addr; resWbData = mem_wdata;
        mem_ready = 1'b1;
      end else if (mem_read && !resRd) begin
        resRd = 1'b1; resRdAddr = mem_addr;
        mem_rdata = memData; mem_ready = 1'b1;
      end
      if (cache_ready) begin
        resData = cache_rdata; done = 1'b1;
        cache_read = 1'b0; cache_write = 1'b0;
      end
    end
    cache_read  = 1'b0;
    cache_write = 1'b0;
    mem_ready   = 1'b0;
    resLat = done ? cyc : -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    doReset();
    total++; if (cache_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%b want=0", cache_ready); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL rst_memRead got=%b want=0", mem_read); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("[TB] FAIL rst_memWrite got=%b want=0", mem_write); end
    total++; if (cache_rdata !== '0) begin bad++; $display("[TB] FAIL rst_rdata got=%h want=0", cache_rdata); end
  endtask

  task automatic test_read_miss_hit();
    logic [LINE_W-1:0] a5;
    a5 = {16{8'hA5}};
    doReset();
    doRequest(1'b0, 28'h0000010, '0, a5);
    total++; if (resRd !== 1'b1) begin bad++; $display("[TB] FAIL rm_memRead got=%b want=1", resRd); end
    total++; if (resRdAddr !== 28'h0000010) begin bad++; $display("[TB] FAIL rm_addr got=%h want=0000010", resRdAddr); end
    total++; if (resWr !== 1'b0) begin bad++; $display("[TB] FAIL rm_noWb got=%b want=0", resWr); end
    total++; if (resData !== a5) begin bad++; $display("[TB] FAIL rm_data got=%h want=%h", resData, a5); end
    total++; if (resLat !== 2) begin bad++; $display("[TB] FAIL rm_lat got=%0d want=2", resLat); end
    doRequest(1'b0, 28'h0000010, '0, '0);
    total++; if (resLat !== 1) begin bad++; $display("[TB] FAIL rh_lat got=%0d want=1", resLat); end
    total++; if (resRd !== 1'b0) begin bad++; $display("[TB] FAIL rh_memRead got=%b want=0", resRd); end
    total++; if (resData !== a5) begin bad++; $display("[TB] FAIL rh_data got=%h want=%h", resData, a5); end
`ifdef L2_CACHE_STATS_EN
    total++; if (stat_hit !== 32'd1) begin bad++; $display("[TB] FAIL st_hit got=%0d want=1", stat_hit); end
    total++; if (stat_miss !== 32'd1) begin bad++; $display("[TB] FAIL st_miss got=%0d want=1", stat_miss); end
    total++; if (stat_wb !== 32'd0) begin bad++; $display("[TB] FAIL st_wb got=%0d want=0", stat_wb); end
`endif
  endtask

  task automatic test_write_alloc();
    int readySeen;
    doReset();
    doRequest(1'b1, 28'h0000020, 128'h1234, '0);
    total++; if (resLat !== 2) begin bad++; $display("[TB] FAIL wa_lat got=%0d want=2", resLat); end
    total++; if (resRd !== 1'b0) begin bad++; $display("[TB] FAIL wa_memRead got=%b want=0", resRd); end
    total++; if (resWr !== 1'b0) begin bad++; $display("[TB] FAIL wa_memWrite got=%b want=0", resWr); end
    doRequest(1'b0, 28'h0000020, '0, '0);
    total++; if (resLat !== 1) begin bad++; $display("[TB] FAIL wa_hitLat got=%0d want=1", resLat); end
    total++; if (resData !== 128'h1234) begin bad++; $display("[TB] FAIL wa_hitData got=%h want=1234", resData); end
    // Both strobes high is illegal: nothing should happen.
    readySeen = 0;
    cache_addr = 28'h0000030; cache_read = 1'b1; cache_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (cache_ready || mem_read || mem_write) readySeen++;
    end
    cache_read = 1'b0; cache_write = 1'b0;
    total++; if (readySeen !== 0) begin bad++; $display("[TB] FAIL illegal_activity got=%0d want=0", readySeen); end
  endtask

  task automatic test_round_robin();
    logic [LINE_W-1:0] d08, d10, d18, d20, m28;
    d08 = 128'hD08; d10 = 128'hD10; d18 = 128'hD18; d20 = 128'hD20; m28 = 128'hF28;
    doReset();
    doRequest(1'b1, 28'h08, d08, '0);
    doRequest(1'b1, 28'h10, d10, '0);
    doRequest(1'b1, 28'h18, d18, '0);
    doRequest(1'b1, 28'h20, d20, '0);
    total++; if (resLat !== 2) begin bad++; $display("[TB] FAIL rr_fillLat got=%0d want=2", resLat); end
    doRequest(1'b0, 28'h28, '0, m28);
    total++; if (resWr !== 1'b1) begin bad++; $display("[TB] FAIL rr_wb1 got=%b want=1", resWr); end
    total++; if (resWbAddr !== 28'h08) begin bad++; $display("[TB] FAIL rr_wb1Addr got=%h want=08", resWbAddr); end
    total++; if (resWbData !== d08) begin bad++; $display("[TB] FAIL rr_wb1Data got=%h want=%h", resWbData, d08); end
    total++; if (resRdAddr !== 28'h28) begin bad++; $display("[TB] FAIL rr_fillAddr got=%h want=28", resRdAddr); end
    total++; if (resData !== m28) begin bad++; $display("[TB] FAIL rr_fillData got=%h want=%h", resData, m28); end
    total++; if (resLat !== 3) begin bad++; $display("[TB] FAIL rr_wbLat got=%0d want=3", resLat); end
    doRequest(1'b0, 28'h30, '0, 128'hF30);
    total++; if (resWbAddr !== 28'h10) begin bad++; $display("[TB] FAIL rr_wb2Addr got=%h want=10", resWbAddr); end
    total++; if (resWbData !== d10) begin bad++; $display("[TB] FAIL rr_wb2Data got=%h want=%h", resWbData, d10); end
    doRequest(1'b0, 28'h08, '0, 128'hF08);
    total++; if (resWbAddr !== 28'h18) begin bad++; $display("[TB] FAIL rr_wb3Addr got=%h want=18", resWbAddr); end
    doRequest(1'b0, 28'h20, '0, '0);
    total++; if (resLat !== 1) begin bad++; $display("[TB] FAIL rr_keepLat got=%0d want=1", resLat); end
    total++; if (resData !== d20) begin bad++; $display("[TB] FAIL rr_keepData got=%h want=%h", resData, d20); end
  endtask

  task automatic test_dirty_writeback();
    doReset();
    doRequest(1'b0, 28'h40, '0, 128'hC40);
    doRequest(1'b1, 28'h40, 128'hBEEF, '0);
    total++; if (resLat !== 1) begin bad++; $display("[TB] FAIL dw_hitLat got=%0d want=1", resLat); end
    doRequest(1'b0, 28'h48, '0, 128'hC48);
    doRequest(1'b0, 28'h50, '0, 128'hC50);
    doRequest(1'b0, 28'h58, '0, 128'hC58);
    total++; if (resWr !== 1'b0) begin bad++; $display("[TB] FAIL dw_invFillWb got=%b want=0", resWr); end
    doRequest(1'b0, 28'h60, '0, 128'hC60);
    total++; if (resWbAddr !== 28'h40) begin bad++; $display("[TB] FAIL dw_wbAddr got=%h want=40", resWbAddr); end
    total++; if (resWbData !== 128'hBEEF) begin bad++; $display("[TB] FAIL dw_wbData got=%h want=beef", resWbData); end
    doRequest(1'b0, 28'h68, '0, 128'hC68);
    total++; if (resWr !== 1'b0) begin bad++; $display("[TB] FAIL dw_cleanWb got=%b want=0", resWr); end
    total++; if (resLat !== 2) begin bad++; $display("[TB] FAIL dw_cleanLat got=%0d want=2", resLat); end
  endtask

  task automatic test_reset_mid();
    doReset();
    doRequest(1'b1, 28'h08, 128'hE08, '0);
    doRequest(1'b1, 28'h10, 128'hE10, '0);
    doRequest(1'b1, 28'h18, 128'hE18, '0);
    doRequest(1'b1, 28'h20, 128'hE20, '0);
    cache_addr = 28'h28; cache_read = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_write !== 1'b1) begin bad++; $display("[TB] FAIL rm_inWb got=%b want=1", mem_write); end
    cache_reset = 1'b1;
    @(posedge clk); #1;
    cache_reset = 1'b0; cache_read = 1'b0;
    total++; if (mem_write !== 1'b0) begin bad++; $display("[TB] FAIL rm_wbDrop got=%b want=0", mem_write); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL rm_rdDrop got=%b want=0", mem_read); end
    total++; if (cache_ready !== 1'b0) begin bad++; $display("[TB] FAIL rm_ready got=%b want=0", cache_ready); end
    doRequest(1'b0, 28'h08, '0, 128'h808);
    total++; if (resRd !== 1'b1) begin bad++; $display("[TB] FAIL rm_postMiss got=%b want=1", resRd); end
    total++; if (resWr !== 1'b0) begin bad++; $display("[TB] FAIL rm_postNoWb got=%b want=0", resWr); end
    total++; if (resData !== 128'h808) begin bad++; $display("[TB] FAIL rm_postData got=%h want=808", resData); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_alloc();
    test_round_robin();
    test_dirty_writeback();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_cache_assoc.md
Name: l2_cache_assoc

Overview:
- Parametrised set-associative, write-back, write-allocate L2 cache between the L1 miss path (line-granular requests) and main memory (line-granular bus).
- Successor to the fixed 8-set single-configuration L2. Generalises set count, ways and line width.
- Adds deterministic victim selection (invalid way first, then per-set round-robin).
- Adds write-miss allocation without a memory fetch, since writes are full-line.

Parameters:
- ADDR_W, 28, line address width (cache_addr / mem_addr)
- LINE_W, 128, line data width
- SET_BITS, 3, log2(number of sets); index = cache_addr[SET_BITS-1:0], tag = cache_addr[ADDR_W-1:SET_BITS]
- WAY_BITS, 2, log2(ways); WAYS = 2**WAY_BITS

Ports:
- clk  in  1  clock, all state on rising edge
- cache_reset  in  1  synchronous, active-high reset
- cache_read  in  1  line read request, held until cache_ready
- cache_write  in  1  full-line write request, held until cache_ready
- cache_addr  in  ADDR_W  line address
- cache_wdata  in  LINE_W  write data
- cache_ready  out  1  one-cycle completion pulse
- cache_rdata  out  LINE_W  read data, valid while cache_ready=1
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  write-back data
- mem_rdata  in  LINE_W  fill data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle per request

Behaviour:
- Interface: one clock (clk); reset (cache_reset) is synchronous and active-high.
- Reset:
  - state IDLE; all valid/dirty bits 0; all round-robin pointers 0.
  - cache_ready, mem_read and mem_write = 0; cache_rdata = 0.
  - Tag/data arrays need not be cleared.
- Lookup (IDLE):
  - Request sampled when exactly one of cache_read/cache_write is high.
  - Both high: illegal, ignored; stay IDLE, no ready.
  - Hit = valid & tag match; multiple matches are impossible, lowest way wins defensively.
- States:
  - IDLE:
    - Read hit: latch line into cache_rdata -> RESPOND.
    - Write hit: write cache_wdata, dirty=1 -> RESPOND.
    - Miss: choose victim (lowest-numbered invalid way, else rr_ptr[set]). Victim valid&dirty -> WRITEBACK. Otherwise read -> FILL, write -> ALLOC.
  - WRITEBACK:
    - mem_write=1, mem_addr={victim_tag,index}, mem_wdata=victim line; all held stable.
    - On mem_ready: read -> FILL, write -> ALLOC.
  - FILL:
    - mem_read=1, mem_addr=cache_addr.
    - On mem_ready: install mem_rdata and tag in victim, valid=1, dirty=0, cache_rdata=mem_rdata -> RESPOND.
  - ALLOC (1 cycle): install cache_wdata and tag in victim, valid=1, dirty=1 -> RESPOND. No memory read.
  - RESPOND: cache_ready=1 for exactly one cycle -> IDLE. The requester drops its request on the following edge.
- Latency:
  - Hit: cache_ready one cycle after the request is first seen in IDLE.
  - Clean write miss: cache_ready two cycles after the request is first seen in IDLE.
  - Other misses: add the memory wait cycles.
- mem_read and mem_write are decoded from state, never both high, and deassert in the cycle after mem_ready.
- Round-robin:
  - rr_ptr[set] advances only when the victim was rr_ptr (not an invalid-way fill).
  - Wraps WAYS-1 -> 0.
- cache_rdata holds its last value between responses. After a write it is undefined, and the bench must not check it.
- Reset mid-operation:
  - The pending transaction is abandoned and dirty data is discarded.
  - mem_read/mem_write are 0 in the first cycle after the reset edge.
- Request signals changing while not in IDLE are illegal; the block samples cache_addr/cache_wdata continuously and the requester must hold them.

Optional Feature:
- L2_CACHE_STATS_EN defined: adds outputs stat_hit, stat_miss and stat_wb (each 32 bits).
  - Counts accepted hits, misses, and completed write-backs.
  - Saturating at 32'hFFFFFFFF; cleared by cache_reset.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, read 0x0000010 -> mem_read=1, mem_addr=0x0000010. mem_ready with mem_rdata=128'hA5A5...A5 -> cache_ready with that data. Reread -> cache_ready 1 cycle later, mem_read stays 0.
- Write miss 0x0000020 with 128'h1234 -> no mem_read, cache_ready 2 cycles after request. Read 0x0000020 -> hit returning 128'h1234.
- Writes to 0x08, 0x10, 0x18, 0x20 (set 0, ways 0-3 filled dirty, rr_ptr stays 0), then read 0x28:
  - Expect mem_write to mem_addr 0x08 with 0x08's data, then mem_read 0x28.
  - A later read 0x30 evicts 0x10 (rr_ptr=1).
- Read miss fills 0x40 clean; write hit 0x40 with 128'hBEEF; force eviction -> write-back of 128'hBEEF to 0x40. A clean line is never written back.
- Assert cache_reset in WRITEBACK with mem_ready low -> mem_write=0 next cycle. A subsequent read of any previously cached address misses.
- L2_CACHE_STATS_EN: after scenario 1 -> stat_hit=1, stat_miss=1, stat_wb=0.
